// File: rtl/gate_tb_pkg.sv
// Shared types for the 2-input gate truth-table checker.
// States, vector index and error-count widths.
package gate_tb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int ERR_W = 3;

  typedef logic [1:0] vec_t;
  typedef logic [ERR_W-1:0] err_cnt_t;

endpackage

// File: rtl/gate_hold_timer.sv
// Hold timer: counts 0..HOLD_CYCLES-1 while enabled.
// Pulses last on the terminal count and wraps to 0.
module gate_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign last = en &&
    (cnt == CW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || last) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Drives a 2-input gate through 00,01,10,11 and scores
// its output against a 4-bit expected truth table.
module gate_truth_checker
  import gate_tb_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  output logic       i1,
  output logic       i2,
  input  logic       o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [2:0] err_count
);

  state_t   state;
  state_t   state_nx;
  vec_t     vec;
  vec_t     drv;
  logic [3:0] exp_q;
  logic     last;
  logic     accept;
  logic     step;
  logic     final_vec;
  logic     mism;
  err_cnt_t cnt_nx;

  gate_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state != APPLY),
    .en   (state == APPLY),
    .last (last)
  );

  assign busy = (state == APPLY);
  assign done = (state == DONE);
  assign {i1, i2} = drv;

  assign step = busy && last;
  assign final_vec = (vec == vec_t'(NUM_VECTORS - 1));

  // An unknown o never compares equal, so it scores as a miss
  always_comb begin
    mism = 1'b1;
    if (o == exp_q[vec]) mism = 1'b0;
  end

  assign cnt_nx = err_count + (mism ? err_cnt_t'(1) : '0);

  always_comb begin
    state_nx = state;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = APPLY;
          accept = 1'b1;
        end
      end
      APPLY: begin
        if (last && final_vec) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      drv       <= '0;
      exp_q     <= '0;
      err_mask  <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        exp_q     <= expected;
        vec       <= '0;
        drv       <= '0;
        err_mask  <= '0;
        err_count <= '0;
        pass      <= 1'b0;
      end else if (step) begin
        if (mism) begin
          err_mask[vec] <= 1'b1;
          err_count     <= cnt_nx;
        end
        if (final_vec) begin
          vec  <= '0;
          drv  <= '0;
          pass <= (cnt_nx == '0);
        end else begin
          vec <= vec + vec_t'(1);
          drv <= vec + vec_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Random and directed runs of gate_truth_checker (H=4 and H=1)
// scored against a truth-table reference model.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0;
  logic start1 = 1'b0;
  logic [3:0] expected = '0;
  logic [3:0] gate_tt = 4'b1000;

  logic i1_4, i2_4, busy_4, done_4, pass_4, o_4;
  logic [3:0] mask_4;
  logic [2:0] cnt_4;
  logic i1_1, i2_1, busy_1, done_1, pass_1, o_1;
  logic [3:0] mask_1;
  logic [2:0] cnt_1;

  logic sel = 1'b0;
  logic m_i1, m_i2, m_busy, m_done, m_pass;
  logic [3:0] m_mask;
  logic [2:0] m_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign o_4 = gate_tt[{i1_4, i2_4}];
  assign o_1 = gate_tt[{i1_1, i2_1}];

  gate_truth_checker #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .expected(expected), .i1(i1_4), .i2(i2_4),
    .o(o_4), .busy(busy_4), .done(done_4),
    .pass(pass_4), .err_mask(mask_4),
    .err_count(cnt_4)
  );

  gate_truth_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .expected(expected), .i1(i1_1), .i2(i2_1),
    .o(o_1), .busy(busy_1), .done(done_1),
    .pass(pass_1), .err_mask(mask_1),
    .err_count(cnt_1)
  );

  always_comb begin
    if (sel) begin
      {m_i1, m_i2, m_busy, m_done} =
        {i1_1, i2_1, busy_1, done_1};
      {m_pass, m_mask, m_cnt} = {pass_1, mask_1, cnt_1};
    end else begin
      {m_i1, m_i2, m_busy, m_done} =
        {i1_4, i2_4, busy_4, done_4};
      {m_pass, m_mask, m_cnt} = {pass_4, mask_4, cnt_4};
    end
  end

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               tag, got, want, $time);
    end
  endtask

  task automatic set_start(input logic s, input logic v);
    if (s) start1 = v;
    else start4 = v;
  endtask

  function automatic int popcnt(input logic [3:0] v);
    int n = 0;
    for (int k = 0; k < 4; k++) n += int'(v[k]);
    return n;
  endfunction

  // pre=1: start was already accepted at the last edge
  task automatic do_run(input logic s, input logic [3:0] ex,
                        input bit keep, input bit pre);
    int h;
    logic [3:0] m;
    int n;
    sel = s;
    h = s ? 1 : 4;
    m = gate_tt ^ ex;
    n = popcnt(m);
    if (!pre) begin
      @(negedge clk);
      expected = ex;
      set_start(s, 1'b1);
      @(posedge clk);
      #1;
      if (!keep) begin
        set_start(s, 1'b0);
        expected = ~ex;
      end
    end
    for (int c = 0; c < 4 * h; c++) begin
      check("apply", 8'({m_busy, m_done, m_i1, m_i2}),
            8'({2'b10, 2'(c / h)}));
      @(posedge clk);
      #1;
    end
    check("done", 8'({m_busy, m_done, m_i1, m_i2}), 8'h4);
    check("mask", 8'(m_mask), 8'(m));
    check("count", 8'(m_cnt), 8'(n));
    check("pass", 8'(m_pass), 8'(n == 0));
    @(posedge clk);
    #1;
    check("post", 8'({m_busy, m_done, m_pass, m_mask}),
          8'({2'b00, n == 0, m}));
  endtask

  initial begin
    logic [3:0] ex;
    #12;
    check("rst", 8'({busy_4, done_4, pass_4, i1_4, i2_4}), 8'h0);
    check("rst_res", 8'({mask_4, 1'b0, cnt_4}), 8'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    gate_tt = 4'b1000;
    do_run(0, 4'b1000, 0, 0);
    gate_tt = 4'b1110;
    do_run(0, 4'b1110, 0, 0);
    do_run(0, 4'b1000, 0, 0);
    check("or_mask", 8'(mask_4), 8'h06);
    gate_tt = 4'b1000;
    do_run(0, 4'b0110, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("persist", 8'({pass_4, mask_4, cnt_4}),
          8'({1'b0, 4'b1110, 3'd3}));

    // start held high: one run, then restart from IDLE
    gate_tt = 4'b1110;
    do_run(0, 4'b1000, 1, 0);
    @(posedge clk);
    #1;
    check("restart", 8'({busy_4, pass_4, mask_4, cnt_4[1:0]}),
          8'h80);
    set_start(0, 1'b0);
    do_run(0, 4'b1000, 0, 1);

    // reset during vector 2
    gate_tt = 4'b1000;
    @(negedge clk);
    expected = 4'b0110;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (2 * 4) @(posedge clk);
    #2;
    check("vec2", 8'({busy_4, i1_4, i2_4, mask_4}),
          8'({1'b1, 2'b10, 4'b0010}));
    rst_n = 1'b0;
    #1;
    check("arst", 8'({busy_4, done_4, pass_4, i1_4, i2_4}), 8'h0);
    check("arst_res", 8'({mask_4, 1'b0, cnt_4}), 8'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", 8'({busy_4, done_4}), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    gate_tt = 4'b1110;
    do_run(0, 4'b1110, 0, 0);

    do_run(1, 4'b1110, 0, 0);

    for (int r = 0; r < 8; r++) begin
      gate_tt = 4'($urandom);
      ex = 4'($urandom);
      do_run(1'($urandom), ex, 0, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking stimulus/response stage for the 2-input gate testbenches. It sits on both sides of a gate under test. It drives `i1`/`i2` through the four input combinations in order 00, 01, 10, 11 and holds each one for a programmable number of cycles. It samples the gate output `o` at the end of each hold and compares it against a 4-bit expected truth table. After the last vector it reports a pass/fail verdict, a per-vector error mask and an error count.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles each vector is held before `o` is sampled; legal range 1..255.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a run; honoured only in IDLE.
- `expected`  in  4  truth table; bit `{i1,i2}` is the expected `o` for that vector; latched on the accepted `start`.
- `i1`  out  1  gate input 1 (registered).
- `i2`  out  1  gate input 2 (registered).
- `o`  in  1  gate output under test.
- `busy`  out  1  high while vectors are being applied.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when `err_count == 0`; valid from `done` until the next accepted `start`.
- `err_mask`  out  4  bit n set when vector n mismatched.
- `err_count`  out  3  number of mismatching vectors, 0..4.

## Operation
- States:
  - IDLE: `start` -> APPLY; latches `expected`; `vec`=0, `cnt`=0; clears `err_mask`/`err_count`/`pass`.
  - APPLY: `cnt` increments each cycle. When `cnt == HOLD_CYCLES-1`: sample `o`, compare with `expected_q[vec]`, update `err_mask[vec]`/`err_count`, reset `cnt`. Then `vec==3` -> DONE; otherwise `vec`+1.
  - DONE: `done`=1 for exactly one cycle; `pass` is set; -> IDLE.
- Outputs `{i1,i2}` equal `vec` while in APPLY, and 00 in IDLE/DONE.
- `busy` = (state == APPLY).
- `start` is ignored in APPLY and DONE. `expected` changes after acceptance have no effect.
- Mismatch: `o` differs from the expected bit. In simulation, X/Z on `o` at the sample edge counts as a mismatch.
- `err_count` saturates at 4 by construction; no wrap.
- `err_mask`, `err_count` and `pass` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: `i1`=0, `i2`=0, `busy`=0, `done`=0, `pass`=0, `err_mask`=0, `err_count`=0, state IDLE, `vec`=0, `cnt`=0.
- `start` is sampled at edge E0. `busy` and `{i1,i2}`=00 are valid after E0.
- Vector n is driven during cycles E0+n·H .. E0+(n+1)·H−1, where H = `HOLD_CYCLES`.
- Vector n is sampled at edge E0+(n+1)·H.
- `done` is high during the cycle following edge E0+4H. `busy` falls at the same edge. The next `start` is accepted at edge E0+4H+2 at the earliest.
- With H=1, each vector lasts one cycle and the whole run is 4 cycles plus 1 DONE cycle.
- `rst_n` low at any point, including mid-run, immediately returns everything to reset values. The partial result is discarded and no `done` pulse is produced.

## Structure
- Shared package `gate_tb_pkg`:
  - state enum {IDLE, APPLY, DONE};
  - `NUM_VECTORS` = 4;
  - vector index type (2 bits);
  - `err_count` width (3).
- `cnt` width is `$clog2(HOLD_CYCLES)`, minimum 1.
- Sub-module `gate_hold_timer`: counts 0..HOLD_CYCLES−1, has a clear input, and asserts a `last` pulse on the terminal count. The FSM, vector register and scoreboard stay in the top module.

## Test plan
- AND2 gate, `expected`=4'b1000, H=4, `start` pulse:
  - `{i1,i2}` steps 00,01,10,11, 4 cycles each;
  - `done` at E0+4H+1;
  - `pass`=1, `err_mask`=0, `err_count`=0.
- OR2 gate, `expected`=4'b1110 -> `pass`=1. Then rerun with `expected`=4'b1000 -> `err_mask`=4'b0110, `err_count`=2, `pass`=0.
- AND2 gate, `expected`=4'b0110 -> `err_mask`=4'b1110, `err_count`=3, `pass`=0. Results persist in IDLE until the next `start`.
- `start` held high throughout the run -> only one run; it restarts only from IDLE, 1 cycle after `done`. Results of run 1 clear at the restart.
- Reset during vector 2 -> all outputs return to reset values asynchronously; no `done`. A new `start` after reset completes normally.
- H=1, OR2, `expected`=4'b1110 -> each vector lasts 1 cycle; `done` at E0+5; `pass`=1.
